// File: rtl/scan_step_seq.sv
// Purpose: steps a DDS through n_steps frequency points per s_start rising edge, triggering one acquisition per point.
// Latency: freq_load 1 cycle after the start edge; acq_trig settle+1 cycles after each freq_load.
// Backpressure: each point waits for acq_done (optionally bounded by acq_timeout); abort returns to idle at once.
//
// Ports:
//   dds, rst_n      - clock (posedge) and synchronous active-low reset
//   s_start, abort  - scan start level (rising edge starts), level abort
//   f_start, f_step, n_steps, settle, acq_timeout - scan setup, captured at start
//   acq_done        - acquisition handshake, honoured only while waiting for it
//   freq_word, freq_load, acq_trig, step_idx - per-point DDS load and trigger
//   busy, scan_done, err_timeout - scan status
module scan_step_seq #(
    parameter int FW_W  = 32,
    parameter int CNT_W = 16,
    parameter int SET_W = 16,
    parameter int TO_W  = 20
) (
    input  logic             dds,
    input  logic             rst_n,
    input  logic             s_start,
    input  logic             abort,
    input  logic [FW_W-1:0]  f_start,
    input  logic [FW_W-1:0]  f_step,
    input  logic [CNT_W-1:0] n_steps,
    input  logic [SET_W-1:0] settle,
    input  logic [TO_W-1:0]  acq_timeout,
    input  logic             acq_done,
    output logic [FW_W-1:0]  freq_word,
    output logic             freq_load,
    output logic             acq_trig,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             scan_done,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t           state;
    logic             s_start_d;
    logic [FW_W-1:0]  f_step_sh;
    logic [CNT_W-1:0] n_steps_sh;
    logic [SET_W-1:0] settle_sh;
    logic [TO_W-1:0]  to_sh;
    logic [SET_W-1:0] set_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             start_edge;
    logic             ack;
    logic [CNT_W-1:0] idx_nxt;
    logic [TO_W-1:0]  to_nxt;

    assign start_edge = s_start & ~s_start_d;
    // acq_trig is high during the first WAIT_ACK cycle; an ack in that same
    // cycle cannot belong to this trigger, so it is discarded.
    assign ack        = acq_done & ~acq_trig;
    assign idx_nxt    = step_idx + CNT_W'(1);
    assign to_nxt     = to_cnt + TO_W'(1);

    always_ff @(posedge dds) begin
        if (!rst_n) begin
            state       <= IDLE;
            // Treat the level as already high so a held s_start is not an edge.
            s_start_d   <= 1'b1;
            freq_word   <= '0;
            step_idx    <= '0;
            freq_load   <= 1'b0;
            acq_trig    <= 1'b0;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            err_timeout <= 1'b0;
            f_step_sh   <= '0;
            n_steps_sh  <= '0;
            settle_sh   <= '0;
            to_sh       <= '0;
            set_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            s_start_d <= s_start;
            freq_load <= 1'b0;
            acq_trig  <= 1'b0;
            scan_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_edge && (n_steps != '0) && !abort) begin
                        f_step_sh   <= f_step;
                        n_steps_sh  <= n_steps;
                        settle_sh   <= settle;
                        to_sh       <= acq_timeout;
                        freq_word   <= f_start;
                        step_idx    <= '0;
                        freq_load   <= 1'b1;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                        set_cnt     <= '0;
                        state       <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (set_cnt == settle_sh) begin
                        acq_trig <= 1'b1;
                        to_cnt   <= '0;
                        state    <= WAIT_ACK;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end

                WAIT_ACK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (ack) begin
                        if (idx_nxt == n_steps_sh) begin
                            scan_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            freq_word <= freq_word + f_step_sh;
                            step_idx  <= idx_nxt;
                            freq_load <= 1'b1;
                            set_cnt   <= '0;
                            state     <= SETTLE;
                        end
                    end else if (to_sh != '0) begin
                        if (to_nxt == to_sh) begin
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            to_cnt <= to_nxt;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_step_seq.sv
// Purpose: scoreboard bench for scan_step_seq; expected pulses are queued at stimulus time.
// Latency: each DUT pulse is matched against the head of the queue by cycle number.
// Backpressure: an acq_done responder answers each acq_trig after a programmable delay.
module tb_scan_step_seq;

    logic        dds = 1'b0;
    logic        rst_n;
    logic        s_start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] settle;
    logic [19:0] acq_timeout;
    logic        acq_done;
    logic [31:0] freq_word;
    logic        freq_load;
    logic        acq_trig;
    logic [15:0] step_idx;
    logic        busy;
    logic        scan_done;
    logic        err_timeout;

    scan_step_seq dut (
        .dds         (dds),
        .rst_n       (rst_n),
        .s_start     (s_start),
        .abort       (abort),
        .f_start     (f_start),
        .f_step      (f_step),
        .n_steps     (n_steps),
        .settle      (settle),
        .acq_timeout (acq_timeout),
        .acq_done    (acq_done),
        .freq_word   (freq_word),
        .freq_load   (freq_load),
        .acq_trig    (acq_trig),
        .step_idx    (step_idx),
        .busy        (busy),
        .scan_done   (scan_done),
        .err_timeout (err_timeout)
    );

    always #5 dds = ~dds;

    int cyc = 0;
    always @(posedge dds) cyc <= cyc + 1;

    // kind: 1 = freq_load, 2 = acq_trig, 3 = scan_done
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] word;
        int          idx;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  push_left;
    int  ack_delay = 0;
    bit  ack_early = 1'b0;
    bit  ack_pend  = 1'b0;
    int  t_ack;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input int c, input logic [31:0] w, input int idx);
        ev_t e;
        if (push_left > 0) begin
            e.kind = kind;
            e.cyc  = c;
            e.word = w;
            e.idx  = idx;
            q.push_back(e);
            push_left--;
        end
    endfunction

    task automatic mon(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("extra_pulse", kind, 0);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_word", freq_word, e.word);
            chk("ev_idx", step_idx, e.idx);
            if (kind == 3) chk("busy_at_done", busy, 0);
            else           chk("busy_in_scan", busy, 1);
        end
    endtask

    // acq_done responder and output monitor, both on the falling edge.
    initial begin
        acq_done = 1'b0;
        forever begin
            @(negedge dds);
            if (!rst_n) begin
                acq_done = 1'b0;
                ack_pend = 1'b0;
            end else begin
                acq_done = 1'b0;
                if (acq_trig && ack_early) acq_done = 1'b1;
                if (ack_pend && cyc == t_ack) begin
                    acq_done = 1'b1;
                    ack_pend = 1'b0;
                end
                if (acq_trig && ack_delay > 0) begin
                    ack_pend = 1'b1;
                    t_ack    = cyc + ack_delay - 1;
                end
                if (freq_load) mon(1);
                if (acq_trig)  mon(2);
                if (scan_done) mon(3);
            end
        end
    end

    // Queues the expected pulse schedule, then raises s_start for one cycle.
    // d = acq_done delay after acq_trig (0 = never answered); lim caps queued events.
    task automatic start_scan(input logic [31:0] fs, input logic [31:0] fst, input int n,
                              input int st, input int to, input int d, input bit early,
                              input int lim);
        int          fl;
        int          tr;
        logic [31:0] w;
        f_start     = fs;
        f_step      = fst;
        n_steps     = 16'(n);
        settle      = 16'(st);
        acq_timeout = 20'(to);
        ack_delay   = d;
        ack_early   = early;
        push_left   = lim;
        fl = cyc + 1;
        w  = fs;
        for (int i = 0; i < n; i++) begin
            push_ev(1, fl, w, i);
            tr = fl + st + 1;
            push_ev(2, tr, w, i);
            if (d == 0) break;
            if (i == n - 1) begin
                push_ev(3, tr + d, w, i);
            end else begin
                fl = tr + d;
                w  = w + fst;
            end
        end
        s_start = 1'b1;
        @(negedge dds);
        s_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge dds);
            n++;
        end
        chk("idle_wait", busy, 0);
        repeat (3) @(negedge dds);
        chk("q_empty", q.size(), 0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge dds);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"}, freq_word, 0);
        chk({tag, "_idx"}, step_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_pulses"}, {freq_load, acq_trig, scan_done}, 0);
    endtask

    initial begin
        int s;
        rst_n       = 1'b0;
        s_start     = 1'b1;
        abort       = 1'b0;
        f_start     = '0;
        f_step      = '0;
        n_steps     = '0;
        settle      = '0;
        acq_timeout = '0;
        push_left   = 0;

        // Reset with s_start already high: release must not start a scan.
        repeat (3) @(negedge dds);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge dds);
        chk("held_start_busy", busy, 0);
        s_start = 1'b0;
        @(negedge dds);
        chk("held_start_q", q.size(), 0);

        // Basic 3-point scan, settle 2, ack 4 cycles after each trigger.
        start_scan(32'h1000, 32'h10, 3, 2, 0, 4, 1'b0, 100);
        wait_idle(200);
        chk("basic_last_word", freq_word, 32'h1020);
        chk("basic_last_idx", step_idx, 2);

        // settle = 0: trigger one cycle after load.
        start_scan(32'h5, 32'h1, 2, 0, 0, 2, 1'b0, 100);
        wait_idle(100);
        chk("settle0_word", freq_word, 32'h6);

        // Frequency word wraps modulo 2^32.
        start_scan(32'hFFFF_FFF0, 32'h20, 2, 1, 0, 3, 1'b0, 100);
        wait_idle(100);
        chk("wrap_word", freq_word, 32'h0000_0010);
        chk("wrap_idx", step_idx, 1);

        // n_steps = 0: edge ignored, outputs untouched.
        start_scan(32'hABCD, 32'h1, 0, 1, 0, 2, 1'b0, 100);
        repeat (10) @(negedge dds);
        chk("nsteps0_busy", busy, 0);
        chk("nsteps0_word", freq_word, 32'h0000_0010);
        chk("nsteps0_q", q.size(), 0);

        // Same-cycle abort and start edge in IDLE: no start.
        abort = 1'b1;
        start_scan(32'h9000, 32'h1, 2, 1, 0, 2, 1'b0, 0);
        abort = 1'b0;
        repeat (5) @(negedge dds);
        chk("abort_start_busy", busy, 0);
        chk("abort_start_word", freq_word, 32'h0000_0010);

        // Timeout of 100 with no ack: trigger at s+3, error 100 cycles after.
        s = cyc + 1;
        start_scan(32'h2000, 32'h1, 3, 2, 100, 0, 1'b0, 100);
        wait_cyc(s + 3 + 99);
        chk("to_err_early", err_timeout, 0);
        chk("to_busy_early", busy, 1);
        @(negedge dds);
        chk("to_err", err_timeout, 1);
        chk("to_busy", busy, 0);
        repeat (5) @(negedge dds);
        chk("to_q_empty", q.size(), 0);
        chk("to_err_sticky", err_timeout, 1);

        // Next valid start clears the sticky error.
        start_scan(32'h3000, 32'h100, 1, 0, 0, 2, 1'b0, 100);
        chk("err_cleared", err_timeout, 0);
        wait_idle(100);

        // Early ack in the trigger cycle and a second start edge while busy.
        start_scan(32'h4000, 32'h8, 2, 1, 0, 4, 1'b1, 100);
        @(negedge dds);
        s_start = 1'b1;
        repeat (2) @(negedge dds);
        s_start = 1'b0;
        wait_idle(100);
        ack_early = 1'b0;
        chk("ignored_word", freq_word, 32'h4008);

        // Abort in SETTLE of point 1 (n_steps = 5).
        s = cyc + 1;
        start_scan(32'h100, 32'h1, 5, 3, 0, 4, 1'b0, 3);
        wait_cyc(s + 9);
        abort = 1'b1;
        @(negedge dds);
        chk("abort_busy", busy, 0);
        chk("abort_idx", step_idx, 1);
        chk("abort_word", freq_word, 32'h101);
        abort = 1'b0;
        repeat (20) @(negedge dds);
        chk("abort_idx_held", step_idx, 1);
        chk("abort_q_empty", q.size(), 0);

        // Reset mid-scan: everything back to zero.
        start_scan(32'h7000, 32'h1, 3, 5, 0, 4, 1'b0, 1);
        @(negedge dds);
        rst_n = 1'b0;
        @(negedge dds);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        repeat (5) @(negedge dds);
        chk("midreset_busy", busy, 0);
        chk("midreset_q", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
